// File: rtl/wptr_full_level.sv
// Write-side pointer, full / almost-full flags and fill level of a dual-clock FIFO.
// Define WPTR_FULL_OVERFLOW_EN to build the sticky woverflow flag; otherwise it is tied low.
module wptr_full_level #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AFULL_LVL = AFULL_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              accept;
  logic              wfull_next;
  logic              afull_next;

  assign accept = winc & ~wfull;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  always_comb begin
    wbinnext   = wbin + {{ADDRSIZE{1'b0}}, accept};
    wgraynext  = (wbinnext >> 1) ^ wbinnext;
    level_next = wbinnext - rbin_s;
    // Full when the pointers match except for the two MSBs (one wrap apart in Gray space).
    wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    afull_next = (level_next >= AFULL_LVL);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_FULL_OVERFLOW_EN
  // Set has priority over clear when both occur on the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) woverflow <= 1'b0;
    else         woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
  end
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = wovf_clr;
  assign woverflow      = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level: directed vector table, corner sequences, and
// randomized traffic against a count-based reference model.
module tb_wptr_full_level;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;
`ifdef WPTR_FULL_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst_n, winc, wovf_clr;
  logic [AW:0]   wq2_rptr;
  logic          wfull, walmost_full, woverflow;
  logic [AW:0]   wlevel, wptr;
  logic [AW-1:0] waddr;

  wptr_full_level #(.ADDRSIZE(AW), .AFULL_THRESH(THR)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .waddr(waddr),
    .wptr(wptr), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of writes accepted and reads seen, no pointer encodings.
  int m_w, m_r, m_level;
  bit m_full, m_afull, m_ovf;

  function automatic logic [AW:0] to_gray(input int cnt);
    logic [AW:0] b;
    b = cnt[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [AW:0] g);
    int b = 0;
    for (int i = AW; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
    return b;
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit inc, input int rcnt, input bit clr);
    bit acc;
    acc = inc && !m_full;
    if (OVF) m_ovf = (inc && m_full) || (m_ovf && !clr);
    m_w     = (m_w + int'(acc)) % (2 * DEPTH);
    m_r     = rcnt % (2 * DEPTH);
    m_level = ((m_w - m_r) % (2 * DEPTH) + 2 * DEPTH) % (2 * DEPTH);
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= THR);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wfull"}, 32'(wfull), 32'(m_full));
    check({tag, ".walmost_full"}, 32'(walmost_full), 32'(m_afull));
    check({tag, ".wlevel"}, 32'(wlevel), 32'(m_level));
    check({tag, ".waddr"}, 32'(waddr), 32'(m_w % DEPTH));
    check({tag, ".wptr"}, 32'(wptr), 32'(to_gray(m_w)));
    check({tag, ".woverflow"}, 32'(woverflow), 32'(m_ovf));
  endtask

  // Apply inputs away from the edge, clock once, update the model, sample 1 time unit later.
  task automatic step(input bit inc, input int rcnt, input bit clr, input string tag);
    winc = inc; wq2_rptr = to_gray(rcnt); wovf_clr = clr;
    @(posedge wclk);
    model_edge(inc, rcnt, clr);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  typedef struct {
    bit          inc;
    logic [AW:0] rg;
    bit          clr;
    bit          e_full;
    bit          e_afull;
    int          e_level;
    int          e_waddr;
    logic [AW:0] e_wptr;
    bit          e_ovf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit inc, input logic [AW:0] rg, input bit clr, input bit f,
                              input bit af, input int lvl, input int wa, input logic [AW:0] wp,
                              input bit ov);
    vec_t v;
    v.inc = inc; v.rg = rg; v.clr = clr; v.e_full = f; v.e_afull = af;
    v.e_level = lvl; v.e_waddr = wa; v.e_wptr = wp; v.e_ovf = ov;
    vt.push_back(v);
  endfunction

  logic [AW:0] prev_wptr;
  int          rhist[$];

  initial begin
    // Fill 16 from empty with the read pointer parked at 0.
    add(1, 5'b00000, 0, 0, 0,  1,  1, 5'b00001, 0);
    add(1, 5'b00000, 0, 0, 0,  2,  2, 5'b00011, 0);
    add(1, 5'b00000, 0, 0, 0,  3,  3, 5'b00010, 0);
    add(1, 5'b00000, 0, 0, 0,  4,  4, 5'b00110, 0);
    add(1, 5'b00000, 0, 0, 0,  5,  5, 5'b00111, 0);
    add(1, 5'b00000, 0, 0, 0,  6,  6, 5'b00101, 0);
    add(1, 5'b00000, 0, 0, 0,  7,  7, 5'b00100, 0);
    add(1, 5'b00000, 0, 0, 0,  8,  8, 5'b01100, 0);
    add(1, 5'b00000, 0, 0, 0,  9,  9, 5'b01101, 0);
    add(1, 5'b00000, 0, 0, 0, 10, 10, 5'b01111, 0);
    add(1, 5'b00000, 0, 0, 0, 11, 11, 5'b01110, 0);
    add(1, 5'b00000, 0, 0, 1, 12, 12, 5'b01010, 0);
    add(1, 5'b00000, 0, 0, 1, 13, 13, 5'b01011, 0);
    add(1, 5'b00000, 0, 0, 1, 14, 14, 5'b01001, 0);
    add(1, 5'b00000, 0, 0, 1, 15, 15, 5'b01000, 0);
    add(1, 5'b00000, 0, 1, 1, 16,  0, 5'b11000, 0);
    // Writes while full hold the pointer; overflow (when built) is set then cleared.
    add(1, 5'b00000, 0, 1, 1, 16,  0, 5'b11000, OVF);
    add(1, 5'b00000, 0, 1, 1, 16,  0, 5'b11000, OVF);
    add(1, 5'b00000, 0, 1, 1, 16,  0, 5'b11000, OVF);
    add(0, 5'b00000, 1, 1, 1, 16,  0, 5'b11000, 0);
    // Read pointer drains in Gray steps 1,3,2,6,7.
    add(0, 5'b00001, 0, 0, 1, 15,  0, 5'b11000, 0);
    add(0, 5'b00011, 0, 0, 1, 14,  0, 5'b11000, 0);
    add(0, 5'b00010, 0, 0, 1, 13,  0, 5'b11000, 0);
    add(0, 5'b00110, 0, 0, 1, 12,  0, 5'b11000, 0);
    add(0, 5'b00111, 0, 0, 0, 11,  0, 5'b11000, 0);

    do_reset();
    foreach (vt[k]) begin
      winc = vt[k].inc; wq2_rptr = vt[k].rg; wovf_clr = vt[k].clr;
      @(posedge wclk);
      model_edge(vt[k].inc, from_gray(vt[k].rg), vt[k].clr);
      #1;
      check($sformatf("vec%0d.wfull", k), 32'(wfull), 32'(vt[k].e_full));
      check($sformatf("vec%0d.walmost_full", k), 32'(walmost_full), 32'(vt[k].e_afull));
      check($sformatf("vec%0d.wlevel", k), 32'(wlevel), 32'(vt[k].e_level));
      check($sformatf("vec%0d.waddr", k), 32'(waddr), 32'(vt[k].e_waddr));
      check($sformatf("vec%0d.wptr", k), 32'(wptr), 32'(vt[k].e_wptr));
      check($sformatf("vec%0d.woverflow", k), 32'(woverflow), 32'(vt[k].e_ovf));
    end

    // Streaming with the read pointer trailing the write count by two edges.
    do_reset();
    rhist = {0, 0};
    prev_wptr = wptr;
    for (int k = 1; k <= 40; k++) begin
      step(1, rhist[0], 0, $sformatf("stream%0d", k));
      rhist.pop_front();
      rhist.push_back(m_w);
      check($sformatf("stream%0d.gray_step", k), 32'($countones(wptr ^ prev_wptr)), 32'd1);
      if (k >= 2) check($sformatf("stream%0d.level2", k), 32'(wlevel), 32'd2);
      prev_wptr = wptr;
    end

    // Asynchronous reset mid-cycle at level 9, then refill to full.
    do_reset();
    for (int k = 0; k < 9; k++) step(1, 0, 0, "pre_rst");
    #2;
    wrst_n = 1'b0;
    #1;
    check("async.wfull", 32'(wfull), 32'd0);
    check("async.walmost_full", 32'(walmost_full), 32'd0);
    check("async.wlevel", 32'(wlevel), 32'd0);
    check("async.waddr", 32'(waddr), 32'd0);
    check("async.wptr", 32'(wptr), 32'd0);
    check("async.woverflow", 32'(woverflow), 32'd0);
    model_reset();
    winc = 1'b0; wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0, $sformatf("refill%0d", k));
      check($sformatf("refill%0d.full_exact", k), 32'(wfull), 32'(k == 16));
    end

    // Accepted write and read advance on the same edge at level 12.
    do_reset();
    for (int k = 0; k < 12; k++) step(1, 0, 0, "to12");
    step(1, 1, 0, "same_edge");
    check("same_edge.level12", 32'(wlevel), 32'd12);
    check("same_edge.afull", 32'(walmost_full), 32'd1);

    // Randomized traffic; the read count never passes the write count.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit inc, clr;
      int r;
      inc = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 9) == 0);
      r   = m_r;
      if (((m_w - m_r + 2 * DEPTH) % (2 * DEPTH)) != 0 && $urandom_range(0, 99) < 40) r = m_r + 1;
      step(inc, r, clr, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
